cordic_phase_shift_arbiter: RTL and testbench
=============================================

Name: cordic_phase_shift_arbiter

Overview:
Shares one cordic_phase_shifter core between NUM_REQ requesters. Requesters submit operations over a valid/ready handshake; the block arbitrates round-robin and drives the core inputs. It tracks each in-flight operation through the core pipeline with a tag shift register and returns the core result to the requester that issued it. It sits between the channel logic and the single shared core instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
LATENCY, 0, core cycles from input applied to output valid (matches core DEPTH)
XY_W, 9, signed width of x/y
P_W, 32, width of phase word and phase_final
CNT_W, 16, width of completed-operation counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
req_valid  in  NUM_REQ  per-requester operation valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_x  in  NUM_REQ*XY_W  flattened signed x, requester i at [i*XY_W +: XY_W]
req_y  in  NUM_REQ*XY_W  flattened signed y
req_p  in  NUM_REQ*P_W  flattened phase word
core_x_in  out  XY_W  to core x_in
core_y_in  out  XY_W  to core y_in
core_p  out  P_W  to core p
core_x_out  in  XY_W  from core x_out
core_y_out  in  XY_W  from core y_out
core_phase_final  in  P_W  from core phase_final
rsp_valid  out  NUM_REQ  per-requester result valid
rsp_ready  in  NUM_REQ  per-requester result accept
rsp_x  out  NUM_REQ*XY_W  flattened result x
rsp_y  out  NUM_REQ*XY_W  flattened result y
rsp_phase  out  NUM_REQ*P_W  flattened result phase_final
busy  out  1  any requester not IDLE
ops_done  out  CNT_W  count of completed response handshakes

Behaviour:
- Reset (async, rst=1): all outputs 0; all channel states IDLE; tag pipeline cleared; RR pointer 0; ops_done 0. In-flight operations are discarded with no response. The integrator drives the core rst_n from ~rst.
- Per-channel FSM, registered: IDLE -> INFLIGHT on accept (req_valid&req_ready). INFLIGHT -> DONE on the edge the owning tag exits the pipeline. DONE -> IDLE on rsp_valid&rsp_ready.
- Each channel has at most one operation outstanding, so no response can be lost.
- Eligible mask = req_valid & (state==IDLE). req_ready is combinational: it selects the first eligible channel searching upward from the RR pointer with wrap. At most one grant per cycle; req_ready is 0 when no channel is eligible.
- On accept of channel g, the pointer becomes (g+1) mod NUM_REQ. The pointer is unchanged when there is no grant.
- Accept in cycle A: core_x_in/core_y_in/core_p are registered from channel g, driven from cycle A+1, and held until the next accept.
- The tag (valid + channel index) enters stage 0 at cycle A+1 and advances one stage per cycle.
- In cycle A+1+LATENCY the core outputs are sampled into channel g's rsp registers, and rsp_valid[g] rises in cycle A+2+LATENCY. Total latency is LATENCY+2 cycles.
- Back-to-back grants to different channels in consecutive cycles are allowed; the core is fully pipelined.
- rsp_x/rsp_y/rsp_phase and rsp_valid are held stable while rsp_ready=0. Data is copied unmodified from the core, with no width change.
- A response handshake returns the channel to IDLE on the next cycle. It becomes eligible for a new accept in the following cycle, never in the same cycle as its response handshake.
- ops_done increments by popcount(rsp_valid&rsp_ready) each cycle and wraps modulo 2^CNT_W.
- busy is registered: OR of (state != IDLE).

Test Plan:
- Reset: hold rst=1 with random inputs -> all outputs 0. Deassert rst with no req_valid -> req_ready=0, busy=0.
- Single op, LATENCY=0, ch2: x=190, y=33, p=0x3555 accepted in cycle A -> core_x_in=190, core_y_in=33, core_p=0x00003555 from A+1. rsp_valid[2]=1 in A+2 with rsp fields equal to core outputs from A+1. ops_done=1 after rsp_ready.
- LATENCY=3, all 4 channels valid from cycle A -> grants ch0..ch3 in A..A+3. rsp_valid[0..3] rise in A+5..A+8, each carrying its own core result.
- Fairness, LATENCY=0, ch0 and ch1 always valid, rsp_ready=1 -> grant sequence 0,1,-,0,1,-. Neither channel is starved and the pointer alternates.
- Backpressure: rsp_ready[1]=0 for 10 cycles -> rsp_valid[1] and its data stay stable and req_ready[1]=0. Channels 0, 2 and 3 keep completing.
- Reset mid-flight, LATENCY=3: assert rst in A+2 after an accept in A -> rsp_valid stays 0, ops_done=0, pointer=0. The first post-reset grant is the lowest valid channel.

Source files
------------

// File: rtl/cordic_phase_shift_arbiter.sv
// cordic_phase_shift_arbiter
//
// Shares one pipelined cordic_phase_shifter core between NUM_REQ requesters.
// Requests are arbitrated round-robin. The selected operands are registered
// onto the core inputs, and a tag (valid + channel index) follows the
// operation through a LATENCY+1 stage shift register. When the tag leaves the
// last stage, the core outputs are captured into the owning channel's
// response registers. Each channel has at most one operation outstanding.
//
// Ports:
//   clk, rst                    clock (rising edge), asynchronous active-high reset
//   req_valid/req_ready         per-requester request handshake (ready is one-hot or zero)
//   req_x/req_y/req_p           flattened operands, requester i at [i*W +: W]
//   core_x_in/core_y_in/core_p  registered operands driven to the shared core
//   core_x_out/core_y_out/core_phase_final  results from the shared core
//   rsp_valid/rsp_ready         per-requester response handshake
//   rsp_x/rsp_y/rsp_phase       flattened per-requester results, held until accepted
//   busy                        registered: some channel is not idle
//   ops_done                    wrapping count of completed response handshakes
module cordic_phase_shift_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 0,
    parameter int XY_W    = 9,
    parameter int P_W     = 32,
    parameter int CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*XY_W-1:0] req_x,
    input  logic [NUM_REQ*XY_W-1:0] req_y,
    input  logic [NUM_REQ*P_W-1:0]  req_p,
    output logic [XY_W-1:0]         core_x_in,
    output logic [XY_W-1:0]         core_y_in,
    output logic [P_W-1:0]          core_p,
    input  logic [XY_W-1:0]         core_x_out,
    input  logic [XY_W-1:0]         core_y_out,
    input  logic [P_W-1:0]          core_phase_final,
    output logic [NUM_REQ-1:0]      rsp_valid,
    input  logic [NUM_REQ-1:0]      rsp_ready,
    output logic [NUM_REQ*XY_W-1:0] rsp_x,
    output logic [NUM_REQ*XY_W-1:0] rsp_y,
    output logic [NUM_REQ*P_W-1:0]  rsp_phase,
    output logic                    busy,
    output logic [CNT_W-1:0]        ops_done
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_INFLIGHT = 2'd1,
        ST_DONE     = 2'd2
    } ch_state_t;

    logic [NUM_REQ-1:0]             eligible;
    logic [NUM_REQ-1:0]             grant;
    logic [NUM_REQ-1:0]             ch_active_next;
    logic [NUM_REQ-1:0]             rsp_hs;
    logic                           grant_any;
    logic [IDX_W-1:0]               grant_idx;
    logic [IDX_W:0]                 cand;
    logic [IDX_W-1:0]               ptr_reg, ptr_next;
    logic [IDX_W:0]                 hs_cnt;
    logic [XY_W-1:0]                core_x_reg, core_y_reg;
    logic [P_W-1:0]                 core_p_reg;
    logic [LATENCY:0]               tag_valid_reg;
    logic [LATENCY:0][IDX_W-1:0]    tag_idx_reg;
    logic                           busy_reg;
    logic [CNT_W-1:0]               ops_done_reg;

    // Round-robin search: first eligible channel at or above the pointer,
    // wrapping. cand is one bit wider so ptr+offset cannot overflow.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = {1'b0, ptr_reg} + (IDX_W+1)'(off);
            if (cand >= (IDX_W+1)'(NUM_REQ)) begin
                cand = cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!grant_any && eligible[cand[IDX_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[IDX_W-1:0];
            end
        end
        if (grant_any) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Ready is forced low while reset is held so every output reads zero.
    assign req_ready = rst ? '0 : grant;

    always_comb begin
        ptr_next = ptr_reg;
        if (grant_any) begin
            ptr_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    assign rsp_hs = rsp_valid & rsp_ready;

    always_comb begin
        hs_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hs_cnt = hs_cnt + {{IDX_W{1'b0}}, rsp_hs[i]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg      <= '0;
            core_x_reg   <= '0;
            core_y_reg   <= '0;
            core_p_reg   <= '0;
            busy_reg     <= 1'b0;
            ops_done_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
            if (grant_any) begin
                core_x_reg <= req_x[grant_idx*XY_W +: XY_W];
                core_y_reg <= req_y[grant_idx*XY_W +: XY_W];
                core_p_reg <= req_p[grant_idx*P_W +: P_W];
            end
            // Built from next state so busy lines up with the channel states.
            busy_reg     <= |ch_active_next;
            ops_done_reg <= ops_done_reg + CNT_W'(hs_cnt);
        end
    end

    // Tag stage s is valid in cycle A+1+s; the last stage marks the cycle in
    // which the core output belongs to this operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_valid_reg <= '0;
            tag_idx_reg   <= '0;
        end else begin
            tag_valid_reg[0] <= grant_any;
            tag_idx_reg[0]   <= grant_idx;
            for (int s = 1; s <= LATENCY; s++) begin
                tag_valid_reg[s] <= tag_valid_reg[s-1];
                tag_idx_reg[s]   <= tag_idx_reg[s-1];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : gen_ch
            ch_state_t       state_reg, state_next;
            logic [XY_W-1:0] rsp_x_reg, rsp_y_reg;
            logic [P_W-1:0]  rsp_phase_reg;
            logic            capture;

            assign capture = tag_valid_reg[LATENCY] &&
                             (tag_idx_reg[LATENCY] == IDX_W'(gi));

            always_comb begin
                state_next = state_reg;
                case (state_reg)
                    ST_IDLE:     if (req_valid[gi] && req_ready[gi]) state_next = ST_INFLIGHT;
                    ST_INFLIGHT: if (capture)                        state_next = ST_DONE;
                    ST_DONE:     if (rsp_ready[gi])                  state_next = ST_IDLE;
                    default:                                         state_next = ST_IDLE;
                endcase
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state_reg     <= ST_IDLE;
                    rsp_x_reg     <= '0;
                    rsp_y_reg     <= '0;
                    rsp_phase_reg <= '0;
                end else begin
                    state_reg <= state_next;
                    if (capture) begin
                        rsp_x_reg     <= core_x_out;
                        rsp_y_reg     <= core_y_out;
                        rsp_phase_reg <= core_phase_final;
                    end
                end
            end

            // A channel that just finished its handshake sits in IDLE for a
            // cycle before it can be granted again.
            assign eligible[gi]       = req_valid[gi] && (state_reg == ST_IDLE);
            assign rsp_valid[gi]      = (state_reg == ST_DONE);
            assign ch_active_next[gi] = (state_next != ST_IDLE);
            assign rsp_x[gi*XY_W +: XY_W]   = rsp_x_reg;
            assign rsp_y[gi*XY_W +: XY_W]   = rsp_y_reg;
            assign rsp_phase[gi*P_W +: P_W] = rsp_phase_reg;
        end
    endgenerate

    assign core_x_in = core_x_reg;
    assign core_y_in = core_y_reg;
    assign core_p    = core_p_reg;
    assign busy      = busy_reg;
    assign ops_done  = ops_done_reg;

endmodule

// File: tb/tb_cordic_phase_shift_arbiter.sv
// Testbench for cordic_phase_shift_arbiter. Two instances share all request
// and response-ready stimulus: u_dut0 (LATENCY=0, combinational core model)
// and u_dut3 (LATENCY=3, three-register core model). Each scenario task
// checks the instance it targets.
module tb_cordic_phase_shift_arbiter;

    localparam int N  = 4;
    localparam int XW = 9;
    localparam int PW = 32;
    localparam int CW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      rsp_ready;
    logic [N*XW-1:0]   req_x, req_y;
    logic [N*PW-1:0]   req_p;

    logic [N-1:0]      d0_req_ready, d3_req_ready;
    logic [XW-1:0]     d0_core_x_in, d0_core_y_in, d3_core_x_in, d3_core_y_in;
    logic [PW-1:0]     d0_core_p, d3_core_p;
    logic [XW-1:0]     d0_core_x_out, d0_core_y_out, d3_core_x_out, d3_core_y_out;
    logic [PW-1:0]     d0_core_phase, d3_core_phase;
    logic [N-1:0]      d0_rsp_valid, d3_rsp_valid;
    logic [N*XW-1:0]   d0_rsp_x, d0_rsp_y, d3_rsp_x, d3_rsp_y;
    logic [N*PW-1:0]   d0_rsp_phase, d3_rsp_phase;
    logic              d0_busy, d3_busy;
    logic [CW-1:0]     d0_ops_done, d3_ops_done;

    int checks = 0;
    int errors = 0;

    // Core model: a fixed transform so each result is traceable to its operands.
    function automatic logic [XW-1:0] fx(input logic [XW-1:0] v);
        return v + 9'd1;
    endfunction
    function automatic logic [XW-1:0] fy(input logic [XW-1:0] v);
        return v - 9'd2;
    endfunction
    function automatic logic [PW-1:0] fp(input logic [PW-1:0] v);
        return v ^ 32'hA5A5_0000;
    endfunction

    assign d0_core_x_out = fx(d0_core_x_in);
    assign d0_core_y_out = fy(d0_core_y_in);
    assign d0_core_phase = fp(d0_core_p);

    logic [XW-1:0] m3_x [3];
    logic [XW-1:0] m3_y [3];
    logic [PW-1:0] m3_p [3];
    always @(posedge clk) begin
        m3_x[0] <= fx(d3_core_x_in);
        m3_y[0] <= fy(d3_core_y_in);
        m3_p[0] <= fp(d3_core_p);
        m3_x[1] <= m3_x[0]; m3_y[1] <= m3_y[0]; m3_p[1] <= m3_p[0];
        m3_x[2] <= m3_x[1]; m3_y[2] <= m3_y[1]; m3_p[2] <= m3_p[1];
    end
    assign d3_core_x_out = m3_x[2];
    assign d3_core_y_out = m3_y[2];
    assign d3_core_phase = m3_p[2];

    cordic_phase_shift_arbiter #(
        .NUM_REQ(N), .LATENCY(0), .XY_W(XW), .P_W(PW), .CNT_W(CW)
    ) u_dut0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(d0_req_ready),
        .req_x(req_x), .req_y(req_y), .req_p(req_p),
        .core_x_in(d0_core_x_in), .core_y_in(d0_core_y_in), .core_p(d0_core_p),
        .core_x_out(d0_core_x_out), .core_y_out(d0_core_y_out),
        .core_phase_final(d0_core_phase),
        .rsp_valid(d0_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_x(d0_rsp_x), .rsp_y(d0_rsp_y), .rsp_phase(d0_rsp_phase),
        .busy(d0_busy), .ops_done(d0_ops_done)
    );

    cordic_phase_shift_arbiter #(
        .NUM_REQ(N), .LATENCY(3), .XY_W(XW), .P_W(PW), .CNT_W(CW)
    ) u_dut3 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(d3_req_ready),
        .req_x(req_x), .req_y(req_y), .req_p(req_p),
        .core_x_in(d3_core_x_in), .core_y_in(d3_core_y_in), .core_p(d3_core_p),
        .core_x_out(d3_core_x_out), .core_y_out(d3_core_y_out),
        .core_phase_final(d3_core_phase),
        .rsp_valid(d3_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_x(d3_rsp_x), .rsp_y(d3_rsp_y), .rsp_phase(d3_rsp_phase),
        .busy(d3_busy), .ops_done(d3_ops_done)
    );

    // Inputs change 1 time unit after the rising edge; outputs are read on the falling edge.
    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic set_ch(input int i, input logic [XW-1:0] x, input logic [XW-1:0] y,
                          input logic [PW-1:0] p);
        req_x[i*XW +: XW] = x;
        req_y[i*XW +: XW] = y;
        req_p[i*PW +: PW] = p;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        advance();
        advance();
        rst = 1'b0;
        advance();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            req_valid = 4'($urandom_range(1, 15));
            rsp_ready = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                set_ch(i, 9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)), $urandom());
            end
            advance();
        end
        settle();
        checks++;
        if ({d0_req_ready, d3_req_ready} !== 8'h00) begin
            errors++;
            $display("FAIL reset_req_ready got %b want 0", {d0_req_ready, d3_req_ready});
        end
        checks++;
        if ({d0_core_x_in, d0_core_y_in, d0_core_p, d3_core_x_in, d3_core_y_in, d3_core_p} !== '0) begin
            errors++;
            $display("FAIL reset_core_in got %h/%h/%h want 0", d0_core_x_in, d0_core_y_in, d0_core_p);
        end
        checks++;
        if ({d0_rsp_valid, d3_rsp_valid} !== 8'h00) begin
            errors++;
            $display("FAIL reset_rsp_valid got %b want 0", {d0_rsp_valid, d3_rsp_valid});
        end
        checks++;
        if ({d0_rsp_x, d0_rsp_y, d0_rsp_phase, d3_rsp_x, d3_rsp_y, d3_rsp_phase} !== '0) begin
            errors++;
            $display("FAIL reset_rsp_data got %h want 0", d0_rsp_phase);
        end
        checks++;
        if ({d0_busy, d3_busy, d0_ops_done, d3_ops_done} !== '0) begin
            errors++;
            $display("FAIL reset_busy_ops got %b %b %0d %0d want 0", d0_busy, d3_busy,
                     d0_ops_done, d3_ops_done);
        end
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        advance();
        advance();
        settle();
        checks++;
        if ({d0_req_ready, d3_req_ready, d0_busy, d3_busy} !== '0) begin
            errors++;
            $display("FAIL post_reset_idle got ready %b %b busy %b %b want 0",
                     d0_req_ready, d3_req_ready, d0_busy, d3_busy);
        end
        $display("reset: outputs cleared and idle after release");
    endtask

    task automatic test_single();
        do_reset();
        set_ch(2, 9'd190, 9'd33, 32'h0000_3555);
        req_valid = 4'b0100;
        settle();
        checks++;
        if (d0_req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL single_grant got %b want 0100", d0_req_ready);
        end
        advance();
        req_valid = '0;
        settle();
        checks++;
        if (d0_core_x_in !== 9'd190 || d0_core_y_in !== 9'd33 || d0_core_p !== 32'h0000_3555) begin
            errors++;
            $display("FAIL single_core_in got %0d/%0d/%h want 190/33/00003555",
                     d0_core_x_in, d0_core_y_in, d0_core_p);
        end
        checks++;
        if (d0_rsp_valid !== 4'b0000 || d0_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_a1_state got rsp_valid %b busy %b want 0000 1", d0_rsp_valid, d0_busy);
        end
        advance();
        settle();
        checks++;
        if (d0_rsp_valid !== 4'b0100) begin
            errors++;
            $display("FAIL single_rsp_valid got %b want 0100", d0_rsp_valid);
        end
        checks++;
        if (d0_rsp_x[2*XW +: XW] !== 9'd191 || d0_rsp_y[2*XW +: XW] !== 9'd31 ||
            d0_rsp_phase[2*PW +: PW] !== 32'hA5A5_3555) begin
            errors++;
            $display("FAIL single_rsp_data got %0d/%0d/%h want 191/31/a5a53555",
                     d0_rsp_x[2*XW +: XW], d0_rsp_y[2*XW +: XW], d0_rsp_phase[2*PW +: PW]);
        end
        rsp_ready = 4'b0100;
        advance();
        settle();
        checks++;
        if (d0_rsp_valid !== 4'b0000 || d0_ops_done !== 16'd1 || d0_busy !== 1'b0) begin
            errors++;
            $display("FAIL single_complete got rsp_valid %b ops %0d busy %b want 0000 1 0",
                     d0_rsp_valid, d0_ops_done, d0_busy);
        end
        $display("single: ch2 x=190 y=33 p=00003555 -> rsp %0d/%0d/%h",
                 d0_rsp_x[2*XW +: XW], d0_rsp_y[2*XW +: XW], d0_rsp_phase[2*PW +: PW]);
    endtask

    task automatic test_pipeline();
        logic [XW-1:0] xs [4] = '{9'd3, 9'd23, 9'd43, 9'd63};
        logic [XW-1:0] ys [4] = '{9'd100, 9'd90, 9'd80, 9'd70};
        logic [PW-1:0] ps [4] = '{32'h0001_1111, 32'h0002_2222, 32'h0003_3333, 32'h0004_4444};
        do_reset();
        for (int i = 0; i < N; i++) set_ch(i, xs[i], ys[i], ps[i]);
        req_valid = 4'hF;
        rsp_ready = 4'hF;
        for (int k = 0; k < 4; k++) begin
            settle();
            checks++;
            if (d3_req_ready !== (4'b0001 << k)) begin
                errors++;
                $display("FAIL pipe_grant%0d got %b want %b", k, d3_req_ready, 4'b0001 << k);
            end
            advance();
        end
        req_valid = '0;
        settle();
        checks++;
        if (d3_rsp_valid !== 4'b0000) begin
            errors++;
            $display("FAIL pipe_early_rsp got %b want 0000", d3_rsp_valid);
        end
        advance();
        for (int g = 0; g < 4; g++) begin
            settle();
            checks++;
            if (d3_rsp_valid !== (4'b0001 << g)) begin
                errors++;
                $display("FAIL pipe_rsp_valid%0d got %b want %b", g, d3_rsp_valid, 4'b0001 << g);
            end
            checks++;
            if (d3_rsp_x[g*XW +: XW] !== fx(xs[g]) || d3_rsp_y[g*XW +: XW] !== fy(ys[g]) ||
                d3_rsp_phase[g*PW +: PW] !== fp(ps[g])) begin
                errors++;
                $display("FAIL pipe_rsp_data%0d got %0d/%0d/%h want %0d/%0d/%h", g,
                         d3_rsp_x[g*XW +: XW], d3_rsp_y[g*XW +: XW], d3_rsp_phase[g*PW +: PW],
                         fx(xs[g]), fy(ys[g]), fp(ps[g]));
            end
            $display("pipeline: ch%0d response x=%0d", g, d3_rsp_x[g*XW +: XW]);
            advance();
        end
        settle();
        checks++;
        if (d3_ops_done !== 16'd4 || d3_rsp_valid !== 4'b0000) begin
            errors++;
            $display("FAIL pipe_ops_done got %0d rsp_valid %b want 4 0000", d3_ops_done, d3_rsp_valid);
        end
    endtask

    task automatic test_fairness();
        logic [N-1:0] exp_g [9] = '{4'b0001, 4'b0010, 4'b0000, 4'b0001, 4'b0010, 4'b0000,
                                   4'b0001, 4'b0010, 4'b0000};
        do_reset();
        req_valid = 4'b0011;
        rsp_ready = 4'hF;
        for (int c = 0; c < 9; c++) begin
            settle();
            checks++;
            if (d0_req_ready !== exp_g[c]) begin
                errors++;
                $display("FAIL fair_grant_c%0d got %b want %b", c, d0_req_ready, exp_g[c]);
            end
            $display("fairness: cycle %0d grant %b", c, d0_req_ready);
            advance();
        end
        req_valid = '0;
        advance();
        advance();
        advance();
        settle();
        checks++;
        if (d0_ops_done !== 16'd6) begin
            errors++;
            $display("FAIL fair_ops_done got %0d want 6", d0_ops_done);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < N; i++) begin
            set_ch(i, 9'(50 + 7*i), 9'(200 - 11*i), 32'hC0DE_0000 + 32'(i));
        end
        req_valid = 4'hF;
        rsp_ready = 4'b1101;
        advance();
        advance();
        advance();
        for (int k = 3; k < 13; k++) begin
            settle();
            checks++;
            if (d0_rsp_valid[1] !== 1'b1 || d0_req_ready[1] !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_c%0d got rsp_valid1 %b req_ready1 %b want 1 0",
                         k, d0_rsp_valid[1], d0_req_ready[1]);
            end
            checks++;
            if (d0_rsp_x[XW +: XW] !== 9'd58 || d0_rsp_y[XW +: XW] !== 9'd187 ||
                d0_rsp_phase[PW +: PW] !== 32'h657B_0001) begin
                errors++;
                $display("FAIL bp_data_c%0d got %0d/%0d/%h want 58/187/657b0001", k,
                         d0_rsp_x[XW +: XW], d0_rsp_y[XW +: XW], d0_rsp_phase[PW +: PW]);
            end
            advance();
        end
        settle();
        checks++;
        if (d0_ops_done !== 16'd10) begin
            errors++;
            $display("FAIL bp_others_done got %0d want 10", d0_ops_done);
        end
        $display("backpressure: ch1 held, others completed %0d", d0_ops_done);
        req_valid = '0;
        rsp_ready = 4'hF;
        for (int c = 0; c < 4; c++) advance();
        settle();
        checks++;
        if (d0_ops_done !== 16'd13 || d0_busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain got ops %0d busy %b want 13 0", d0_ops_done, d0_busy);
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        set_ch(1, 9'd77, 9'd66, 32'h1234_5678);
        req_valid = 4'b0010;
        rsp_ready = 4'hF;
        settle();
        checks++;
        if (d3_req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL mid_grant got %b want 0010", d3_req_ready);
        end
        advance();
        req_valid = '0;
        advance();
        rst = 1'b1;
        #1;
        checks++;
        if (d3_rsp_valid !== 4'b0000 || d3_ops_done !== 16'd0 || d3_busy !== 1'b0 ||
            d3_core_x_in !== 9'd0) begin
            errors++;
            $display("FAIL mid_in_reset got rsp %b ops %0d busy %b x %0d want 0",
                     d3_rsp_valid, d3_ops_done, d3_busy, d3_core_x_in);
        end
        advance();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            settle();
            checks++;
            if (d3_rsp_valid !== 4'b0000 || d3_ops_done !== 16'd0) begin
                errors++;
                $display("FAIL mid_discard_c%0d got rsp %b ops %0d want 0000 0",
                         c, d3_rsp_valid, d3_ops_done);
            end
            advance();
        end
        req_valid = 4'b1010;
        settle();
        checks++;
        if (d3_req_ready !== 4'b0010) begin
            errors++;
            $display("FAIL mid_first_grant got %b want 0010", d3_req_ready);
        end
        $display("reset_midflight: first grant after reset %b", d3_req_ready);
        req_valid = '0;
        advance();
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        req_x     = '0;
        req_y     = '0;
        req_p     = '0;
        test_reset();
        test_single();
        test_pipeline();
        test_fairness();
        test_backpressure();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "timeout");
    end

endmodule
